// File: rtl/ritc_auto_align.sv
// Automatic bitslip trainer: walks every deserialized lane, slipping each one until its
// sample word matches the training pattern for MATCH_CYCLES consecutive cycles.
module ritc_auto_align #(
    parameter int unsigned NCH           = 6,
    parameter int unsigned NBIT          = 12,
    parameter int unsigned DESER         = 4,
    parameter logic [DESER-1:0] PATTERN  = 4'b1100,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned MATCH_CYCLES  = 16,
    parameter int unsigned MAX_SLIPS     = 8,
    localparam int unsigned NLANE        = NCH * NBIT,
    localparam int unsigned LW           = (NLANE > 1) ? $clog2(NLANE) : 1
) (
    input  logic                        SYSCLK,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [NCH*NBIT*DESER-1:0]   data_i,
    output logic [NLANE-1:0]            bitslip_o,
    output logic                        train_on_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        fail_o,
    output logic [NLANE-1:0]            fail_mask_o,
    output logic [LW-1:0]               lane_o
);

    localparam int unsigned SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int unsigned MCW = (MATCH_CYCLES > 1) ? $clog2(MATCH_CYCLES + 1) : 1;
    localparam int unsigned SLW = (MAX_SLIPS > 1) ? $clog2(MAX_SLIPS + 1) : 1;

    localparam logic [SCW-1:0] SettleLast = SCW'(SETTLE_CYCLES - 1);
    localparam logic [MCW-1:0] MatchLast  = MCW'(MATCH_CYCLES - 1);
    localparam logic [SLW-1:0] SlipMax    = SLW'(MAX_SLIPS);
    localparam logic [LW-1:0]  LaneLast   = LW'(NLANE - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StCheck,
        StSlip,
        StNext,
        StDone
    } state_t;

    state_t             state;
    logic [SCW-1:0]     settle_cnt;
    logic [MCW-1:0]     match_cnt;
    logic [SLW-1:0]     slips;

    logic [NLANE-1:0][DESER-1:0] lane_words;
    logic [NLANE-1:0]            lane_onehot;
    logic                        lane_match;

    // Regroup the channel-major input so each lane's DESER samples sit together.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        for (genvar b = 0; b < NBIT; b++) begin : g_bit
            for (genvar s = 0; s < DESER; s++) begin : g_smp
                assign lane_words[c*NBIT+b][s] = data_i[(c*DESER+s)*NBIT+b];
            end
        end
    end

    assign lane_match = (lane_words[lane_o] == PATTERN);

    always_comb begin
        lane_onehot         = '0;
        lane_onehot[lane_o] = 1'b1;
    end

    always_ff @(posedge SYSCLK) begin
        if (rst_i) begin
            state       <= StIdle;
            settle_cnt  <= '0;
            match_cnt   <= '0;
            slips       <= '0;
            lane_o      <= '0;
            bitslip_o   <= '0;
            train_on_o  <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            fail_o      <= 1'b0;
            fail_mask_o <= '0;
        end else begin
            bitslip_o <= '0;
            case (state)
                StIdle, StDone: begin
                    if (start_i) begin
                        state       <= StSettle;
                        lane_o      <= '0;
                        slips       <= '0;
                        settle_cnt  <= '0;
                        fail_mask_o <= '0;
                        fail_o      <= 1'b0;
                        done_o      <= 1'b0;
                        busy_o      <= 1'b1;
                        train_on_o  <= 1'b1;
                    end
                end
                StSettle: begin
                    if (settle_cnt == SettleLast) begin
                        state     <= StCheck;
                        match_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                StCheck: begin
                    if (lane_match) begin
                        if (match_cnt == MatchLast) begin
                            state <= StNext;
                        end else begin
                            match_cnt <= match_cnt + 1'b1;
                        end
                    end else if (slips == SlipMax) begin
                        fail_mask_o[lane_o] <= 1'b1;
                        state               <= StNext;
                    end else begin
                        bitslip_o <= lane_onehot;
                        state     <= StSlip;
                    end
                end
                StSlip: begin
                    slips      <= slips + 1'b1;
                    settle_cnt <= '0;
                    state      <= StSettle;
                end
                StNext: begin
                    if (lane_o == LaneLast) begin
                        state      <= StDone;
                        done_o     <= 1'b1;
                        busy_o     <= 1'b0;
                        train_on_o <= 1'b0;
                        fail_o     <= |fail_mask_o;
                    end else begin
                        lane_o     <= lane_o + 1'b1;
                        slips      <= '0;
                        settle_cnt <= '0;
                        state      <= StSettle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
